lane_serializer: RTL and testbench

- Consumes one 128-bit word per valid/ready handshake and replays it as a stream of 16-bit lanes on a downstream valid/ready interface.
- Sits at the output of the translate stage, the other end of its data_out/valid_out interface.
- Feeds sample-rate consumers, such as the audio DAC path and the UART dump, that take one 16-bit value per handshake.

---
 rtl/lane_serializer_pkg.sv | 17 +
 rtl/lane_serializer.sv | 151 +++++++++++++++
 tb/tb_lane_serializer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_serializer_pkg.sv
// Shared types and default widths for the word-to-lane serializer and the
// translate stage that feeds it.
package lane_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int WORD_WIDTH_DEF = 128;
    localparam int LANE_WIDTH_DEF = 16;

    function automatic int lane_count(input int word_width, input int lane_width);
        return word_width / lane_width;
    endfunction

endpackage

// File: rtl/lane_serializer.sv
// Replays each accepted WORD_WIDTH word as LANE_WIDTH lanes, MSB lane first.
// Define LANE_SERIALIZER_SKID_EN to add a one-word holding buffer (zero-bubble streaming).
module lane_serializer
    import lane_serializer_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int LANE_WIDTH = LANE_WIDTH_DEF
) (
    input  logic                                         clk_in,
    input  logic                                         rst_in,
    input  logic [WORD_WIDTH-1:0]                        data_in,
    input  logic                                         valid_in,
    output logic                                         ready_out,
    output logic [LANE_WIDTH-1:0]                        data_out,
    output logic                                         valid_out,
    input  logic                                         ready_in,
    output logic                                         last_out,
    output logic [$clog2(WORD_WIDTH/LANE_WIDTH)-1:0]     lane_idx_out
);

    localparam int LANES = lane_count(WORD_WIDTH, LANE_WIDTH);
    localparam int IDX_W = $clog2(LANES);

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t LAST_IDX = idx_t'(LANES - 1);

    if ((WORD_WIDTH % LANE_WIDTH) != 0 || LANES < 2) begin : g_width_check
        $error("lane_serializer: WORD_WIDTH must be an integer multiple (>=2) of LANE_WIDTH");
    end

    state_t                state_q, state_n;
    logic [WORD_WIDTH-1:0] word_q, word_n;
    idx_t                  idx_q, idx_n;

    logic                  valid_n, ready_n, last_n;
    logic [LANE_WIDTH-1:0] data_n;

    logic accept;
    logic out_hs;
    logic last_hs;

`ifdef LANE_SERIALIZER_SKID_EN
    logic                  buf_full_q, buf_full_n;
    logic [WORD_WIDTH-1:0] buf_word_q, buf_word_n;
`endif

    assign accept       = valid_in && ready_out;
    assign out_hs       = valid_out && ready_in;
    assign last_hs      = out_hs && (idx_q == LAST_IDX);
    assign lane_idx_out = idx_q;

    // NOTE: every variable written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_n = state_q;
        word_n  = word_q;
        idx_n   = idx_q;
`ifdef LANE_SERIALIZER_SKID_EN
        buf_full_n = buf_full_q;
        buf_word_n = buf_word_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_n  = data_in;
                    idx_n   = '0;
                    state_n = SEND;
                end
            end

            SEND: begin
                if (last_hs) begin
`ifdef LANE_SERIALIZER_SKID_EN
                    // A parked word takes priority; ready_out is low while it is held.
                    if (buf_full_q) begin
                        word_n     = buf_word_q;
                        idx_n      = '0;
                        buf_full_n = 1'b0;
                    end else if (accept) begin
                        word_n = data_in;
                        idx_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
`else
                    state_n = IDLE;
`endif
                end else begin
                    if (out_hs) begin
                        idx_n = idx_q + idx_t'(1);
                    end
`ifdef LANE_SERIALIZER_SKID_EN
                    if (accept) begin
                        buf_word_n = data_in;
                        buf_full_n = 1'b1;
                    end
`endif
                end
            end

            default: state_n = IDLE;
        endcase

        valid_n = (state_n == SEND);
`ifdef LANE_SERIALIZER_SKID_EN
        ready_n = !buf_full_n;
`else
        ready_n = (state_n == IDLE);
`endif
        last_n = valid_n && (idx_n == LAST_IDX);
        data_n = valid_n ? word_n[WORD_WIDTH-1 - int'(idx_n)*LANE_WIDTH -: LANE_WIDTH] : '0;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            word_q    <= '0;
            idx_q     <= '0;
            valid_out <= 1'b0;
            ready_out <= 1'b0;
            last_out  <= 1'b0;
            data_out  <= '0;
        end else begin
            state_q   <= state_n;
            word_q    <= word_n;
            idx_q     <= idx_n;
            valid_out <= valid_n;
            ready_out <= ready_n;
            last_out  <= last_n;
            data_out  <= data_n;
        end
    end

`ifdef LANE_SERIALIZER_SKID_EN
    // The parked word is cleared too, so nothing from before a reset can reappear.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            buf_full_q <= 1'b0;
            buf_word_q <= '0;
        end else begin
            buf_full_q <= buf_full_n;
            buf_word_q <= buf_word_n;
        end
    end
`endif

endmodule

// File: tb/tb_lane_serializer.sv
// Self-checking bench for lane_serializer: directed scenarios plus a randomized
// stream, all compared against a lane-splitting reference model.
module tb_lane_serializer;

    localparam int WW    = 128;
    localparam int LW    = 16;
    localparam int LANES = 8;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  idx;
        logic        last;
    } lane_t;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [WW-1:0] data_in;
    logic          valid_in;
    logic          ready_out;
    logic [LW-1:0] data_out;
    logic          valid_out;
    logic          ready_in;
    logic          last_out;
    logic [2:0]    lane_idx_out;

    int errors = 0;
    int checks = 0;

    // Reference model: accepted words become pending lanes; each output
    // handshake moves the next pending lane into the expected stream.
    lane_t pend_q[$];
    lane_t exp_q[$];
    lane_t obs_q[$];
    int    acc_count = 0;
    logic  acc_valid_out = 1'b0;

    always #5 clk_in = ~clk_in;

    lane_serializer dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .last_out     (last_out),
        .lane_idx_out (lane_idx_out)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lane_of(input logic [WW-1:0] w, input int k);
        logic [WW-1:0] s;
        s = w >> (WW - LW*(k+1));
        return s[15:0];
    endfunction

    function automatic logic [WW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic lane_t exp_lane(input logic [WW-1:0] w, input int k);
        lane_t l;
        l.data = lane_of(w, k);
        l.idx  = 3'(k);
        l.last = (k == LANES-1);
        return l;
    endfunction

    // One clock: snapshot handshakes at the falling edge, let the rising edge
    // happen, then update the model. Returns 1 ns after the rising edge.
    task automatic step();
        logic          hs, acc, rst, vo;
        lane_t         ob;
        logic [WW-1:0] w;
        @(negedge clk_in);
        rst = rst_in;
        hs  = valid_out && ready_in;
        acc = valid_in && ready_out;
        vo  = valid_out;
        ob  = {data_out, lane_idx_out, last_out};
        w   = data_in;
        @(posedge clk_in);
        #1;
        if (rst) begin
            pend_q.delete();
        end else begin
            if (hs) begin
                obs_q.push_back(ob);
                if (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
            end
            if (acc) begin
                for (int k = 0; k < LANES; k++) pend_q.push_back(exp_lane(w, k));
                acc_count++;
                acc_valid_out = vo;
            end
        end
    endtask

    task automatic clear_model();
        pend_q.delete();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        int start;
        start    = acc_count;
        valid_in = 1'b1;
        data_in  = w;
        for (int i = 0; i < 20 && acc_count == start; i++) step();
        valid_in = 1'b0;
        data_in  = rand_word();
        checks++;
        if (acc_count == start) begin
            errors++;
            $display("FAIL send_word: word %h not accepted in 20 cycles, ready_out=%b required 1", w, ready_out);
        end
    endtask

    task automatic test_reset();
        rst_in   = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        data_in  = '0;
        step();
        step();
        checks++;
        if ({ready_out, valid_out, last_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/valid/last=%b required 000", {ready_out, valid_out, last_out});
        end
        checks++;
        if ({data_out, lane_idx_out} !== 19'd0) begin
            errors++;
            $display("FAIL reset_data: data_out=%h lane_idx=%0d required 0/0", data_out, lane_idx_out);
        end
        rst_in = 1'b0;
        step();
        checks++;
        if ({ready_out, valid_out} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: ready/valid=%b required 10", {ready_out, valid_out});
        end
    endtask

    task automatic test_basic();
        logic [WW-1:0] w;
        clear_model();
        w = 128'h0003_0004_0003_0004_0003_0004_0003_0004;
        ready_in = 1'b1;
        send_word(w);
        for (int k = 0; k < LANES; k++) begin
            checks++;
            if ({valid_out, data_out, lane_idx_out, last_out} !==
                {1'b1, (k % 2 == 1) ? 16'h0004 : 16'h0003, 3'(k), 1'(k == 7)}) begin
                errors++;
                $display("FAIL basic lane %0d: v=%b d=%h i=%0d l=%b required v=1 d=%h i=%0d l=%b",
                         k, valid_out, data_out, lane_idx_out, last_out,
                         (k % 2 == 1) ? 16'h0004 : 16'h0003, k, k == 7);
            end
            step();
        end
        checks++;
        if ({valid_out, ready_out} !== 2'b01) begin
            errors++;
            $display("FAIL basic_end: valid/ready=%b required 01", {valid_out, ready_out});
        end
    endtask

    task automatic test_backpressure();
        logic [WW-1:0] w;
        clear_model();
        w = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
        ready_in = 1'b1;
        send_word(w);
        for (int i = 0; i < 10 && lane_idx_out != 3'd3; i++) step();
        ready_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({valid_out, data_out, lane_idx_out, last_out} !== {1'b1, 16'h0004, 3'd3, 1'b0}) begin
                errors++;
                $display("FAIL backpressure hold %0d: v=%b d=%h i=%0d l=%b required v=1 d=0004 i=3 l=0",
                         c, valid_out, data_out, lane_idx_out, last_out);
            end
        end
        ready_in = 1'b1;
        for (int k = 3; k < LANES; k++) begin
            checks++;
            if ({data_out, lane_idx_out, last_out} !== {16'(k + 1), 3'(k), 1'(k == 7)}) begin
                errors++;
                $display("FAIL backpressure resume %0d: d=%h i=%0d l=%b required d=%h i=%0d",
                         k, data_out, lane_idx_out, last_out, 16'(k + 1), k);
            end
            step();
        end
        checks++;
        if (obs_q.size() != LANES || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_count: lanes=%0d valid_out=%b required %0d/0", obs_q.size(), valid_out, LANES);
        end
    endtask

    task automatic test_ignored_input();
        logic [WW-1:0] w;
        int            start;
        clear_model();
        w        = rand_word();
        ready_in = 1'b1;
        send_word(w);
        start    = acc_count;
        valid_in = 1'b1;
        data_in  = {WW{1'b1}};
        for (int k = 0; k < LANES; k++) begin
            checks++;
            if ({ready_out, data_out} !== {1'b0, lane_of(w, k)}) begin
                errors++;
                $display("FAIL ignored lane %0d: ready=%b d=%h required ready=0 d=%h",
                         k, ready_out, data_out, lane_of(w, k));
            end
            step();
        end
        valid_in = 1'b0;
        data_in  = rand_word();
        step();
        checks++;
        if (valid_out !== 1'b0 || acc_count != start) begin
            errors++;
            $display("FAIL ignored_accept: valid_out=%b extra_accepts=%0d required 0/0", valid_out, acc_count - start);
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].data === 16'hFFFF || obs_q[i] !== exp_lane(w, i)) begin
                errors++;
                $display("FAIL ignored_stream %0d: got %h required %h", i, obs_q[i].data, lane_of(w, i));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [WW-1:0] w;
        clear_model();
        w        = rand_word();
        ready_in = 1'b1;
        send_word(w);
        step();
        step();
        step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        checks++;
        if ({valid_out, last_out, data_out, ready_out, lane_idx_out} !== 22'd0) begin
            errors++;
            $display("FAIL reset_mid: v=%b l=%b d=%h r=%b i=%0d required all 0",
                     valid_out, last_out, data_out, ready_out, lane_idx_out);
        end
        step();
        checks++;
        if ({ready_out, valid_out} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_release: ready/valid=%b required 10", {ready_out, valid_out});
        end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (valid_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_stale %0d: valid_out=%b d=%h required 0", c, valid_out, data_out);
            end
        end
        checks++;
        if (obs_q.size() != 3) begin
            errors++;
            $display("FAIL reset_mid_count: lanes=%0d required 3", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_lane(w, i)) begin
                errors++;
                $display("FAIL reset_mid_lane %0d: got %h required %h", i, obs_q[i].data, lane_of(w, i));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WW-1:0] a, b;
        int            start, first, last, gaps, exp_gaps;
        logic          b_vo, exp_b_vo;
        logic          hist[$];
        clear_model();
        a = 128'h0000_0001_0002_0003_0004_0005_0006_0007;
        b = 128'h0010_0011_0012_0013_0014_0015_0016_0017;
        start    = acc_count;
        b_vo     = 1'bx;
        ready_in = 1'b1;
        valid_in = 1'b1;
        data_in  = a;
        for (int c = 0; c < 60 && obs_q.size() < 16; c++) begin
            step();
            hist.push_back(valid_out);
            if (acc_count == start + 1 && data_in === a) begin
                data_in = b;
            end else if (acc_count == start + 2 && valid_in) begin
                valid_in = 1'b0;
                b_vo     = acc_valid_out;
                data_in  = rand_word();
            end
        end
        checks++;
        if (obs_q.size() != 16) begin
            errors++;
            $display("FAIL b2b_count: lanes=%0d required 16", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== {(i < 8) ? 16'(i) : 16'(16'h10 + i - 8), 3'(i % 8), 1'(i % 8 == 7)}) begin
                errors++;
                $display("FAIL b2b_lane %0d: d=%h i=%0d l=%b", i, obs_q[i].data, obs_q[i].idx, obs_q[i].last);
            end
        end
        first = -1;
        last  = -1;
        for (int i = 0; i < hist.size(); i++) begin
            if (hist[i] === 1'b1) begin
                if (first < 0) first = i;
                last = i;
            end
        end
        gaps = 0;
        for (int i = first; i >= 0 && i <= last; i++) if (hist[i] !== 1'b1) gaps++;
`ifdef LANE_SERIALIZER_SKID_EN
        exp_gaps = 0;
        exp_b_vo = 1'b1;
`else
        exp_gaps = 1;
        exp_b_vo = 1'b0;
`endif
        checks++;
        if (gaps != exp_gaps) begin
            errors++;
            $display("FAIL b2b_gap: bubbles=%0d required %0d", gaps, exp_gaps);
        end
        checks++;
        if (b_vo !== exp_b_vo) begin
            errors++;
            $display("FAIL b2b_accept_during_send: valid_out at B accept=%b required %b", b_vo, exp_b_vo);
        end
    endtask

    task automatic test_random();
        localparam int N = 24;
        logic [WW-1:0] words[N];
        int            sent, start, cyc;
        clear_model();
        for (int i = 0; i < N; i++) words[i] = rand_word();
        sent     = 0;
        cyc      = 0;
        valid_in = 1'b0;
        while ((sent < N || obs_q.size() < LANES*N) && cyc < 3000) begin
            ready_in = ($urandom_range(0, 3) != 0);
            if (!valid_in && sent < N && $urandom_range(0, 1) == 1) begin
                valid_in = 1'b1;
                data_in  = words[sent];
            end
            start = acc_count;
            step();
            cyc++;
            if (acc_count != start) begin
                sent++;
                valid_in = 1'b0;
                data_in  = rand_word();
            end
        end
        ready_in = 1'b1;
        checks++;
        if (obs_q.size() != LANES*N) begin
            errors++;
            $display("FAIL random_count: lanes=%0d required %0d", obs_q.size(), LANES*N);
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_lane(words[i / LANES], i % LANES) || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_lane %0d: d=%h i=%0d l=%b required d=%h i=%0d",
                         i, obs_q[i].data, obs_q[i].idx, obs_q[i].last,
                         lane_of(words[i / LANES], i % LANES), i % LANES);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
`ifndef LANE_SERIALIZER_SKID_EN
        test_ignored_input();
`endif
        test_reset_mid();
        test_back_to_back();
        step();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
